// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for pll_reconfig_seq: register map, fixed data words,
// FSM states and the eight-entry reconfiguration write table.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C0    = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_BW    = 6'd8;
    localparam logic [5:0] ADDR_CP    = 6'd9;

    localparam logic [31:0] DATA_N  = 32'h0001_0000;
    localparam logic [31:0] DATA_CP = 32'd1;
    localparam logic [31:0] DATA_BW = 32'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_GAP,
        S_PRST,
        S_LOCKWAIT,
        S_FIN
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_M,
        SEL_K,
        SEL_N,
        SEL_C0,
        SEL_CP,
        SEL_BW
    } dsel_e;

    typedef struct packed {
        logic [5:0] addr;
        dsel_e      dsel;
    } wr_entry_t;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] k;
        logic [31:0] c0;
    } cfg_t;

    // Order matters: the controller expects mode first and start last.
    function automatic wr_entry_t wr_entry(input logic [2:0] idx);
        wr_entry_t e;
        case (idx)
            3'd0:    e = '{ADDR_MODE, SEL_ZERO};
            3'd1:    e = '{ADDR_M, SEL_M};
            3'd2:    e = '{ADDR_K, SEL_K};
            3'd3:    e = '{ADDR_N, SEL_N};
            3'd4:    e = '{ADDR_C0, SEL_C0};
            3'd5:    e = '{ADDR_CP, SEL_CP};
            3'd6:    e = '{ADDR_BW, SEL_BW};
            default: e = '{ADDR_START, SEL_ZERO};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq.sv
// Writes the PLL reconfiguration sequence over Avalon-MM, pulses pll_reset and waits for lock.
// Optional per-write readback verification is enabled with `define PLLRECFG_READBACK_EN.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int GAP_CYCLES   = 8,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 5000000
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        req,
    input  logic [31:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [31:0] cfg_c0,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        pll_reset
`ifdef PLLRECFG_READBACK_EN
    ,
    output logic        mgmt_read,
    input  logic [31:0] mgmt_readdata,
    output logic        cfg_mismatch
`endif
);

    localparam int GAP_W  = (GAP_CYCLES   > 1) ? $clog2(GAP_CYCLES)   : 1;
    localparam int RST_W  = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int LOCK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [RST_W-1:0]  rst_q, rst_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    cfg_t              shd_q, shd_d;
    cfg_t              pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              error_q, error_d;
    wr_entry_t         entry;
    logic [31:0]       wr_data;
    cfg_t              cfg_in;
`ifdef PLLRECFG_READBACK_EN
    logic              mismatch_q, mismatch_d;
`endif

    assign cfg_in = '{cfg_m, cfg_k, cfg_c0};

    always_comb begin
        entry = wr_entry(idx_q);
        case (entry.dsel)
            SEL_M:   wr_data = shd_q.m;
            SEL_K:   wr_data = shd_q.k;
            SEL_N:   wr_data = DATA_N;
            SEL_C0:  wr_data = shd_q.c0;
            SEL_CP:  wr_data = DATA_CP;
            SEL_BW:  wr_data = DATA_BW;
            default: wr_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        rst_d        = rst_q;
        lock_d       = lock_q;
        shd_d        = shd_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        error_d      = error_q;
`ifdef PLLRECFG_READBACK_EN
        mismatch_d   = mismatch_q;
`endif
        // A request while busy only parks in the pending slot; the running sequence is never cut short.
        if (req && state_q != S_IDLE) begin
            pend_d       = cfg_in;
            pend_valid_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    shd_d   = cfg_in;
                    error_d = 1'b0;
`ifdef PLLRECFG_READBACK_EN
                    mismatch_d = 1'b0;
`endif
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!mgmt_waitrequest) begin
                    gap_d   = '0;
`ifdef PLLRECFG_READBACK_EN
                    state_d = S_READ;
`else
                    state_d = S_GAP;
`endif
                end
            end
            S_READ: begin
`ifdef PLLRECFG_READBACK_EN
                if (!mgmt_waitrequest) begin
                    if (idx_q != 3'd0 && idx_q != 3'd7 && mgmt_readdata != wr_data)
                        mismatch_d = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
`else
                state_d = S_GAP;
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == 3'd7) begin
                        rst_d   = '0;
                        state_d = S_PRST;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_WRITE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_PRST: begin
                if (rst_q == RST_LAST) begin
                    lock_d  = '0;
                    state_d = S_LOCKWAIT;
                end else begin
                    rst_d = rst_q + RST_W'(1);
                end
            end
            S_LOCKWAIT: begin
                if (pll_locked) begin
                    state_d = S_FIN;
                end else if (lock_q == LOCK_LAST) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            S_FIN: begin
                // A request landing in this cycle is served straight away, same as an older pending one.
                if (req || pend_valid_q) begin
                    shd_d        = req ? cfg_in : pend_q;
                    pend_valid_d = 1'b0;
                    idx_d        = '0;
                    state_d      = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            rst_q        <= '0;
            lock_q       <= '0;
            shd_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            rst_q        <= rst_d;
            lock_q       <= lock_d;
            shd_q        <= shd_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            error_q      <= error_d;
        end
    end

`ifdef PLLRECFG_READBACK_EN
    always_ff @(posedge CLK_50M) begin
        if (RESET) mismatch_q <= 1'b0;
        else       mismatch_q <= mismatch_d;
    end

    assign mgmt_read    = (state_q == S_READ) && !RESET;
    assign cfg_mismatch = mismatch_q;
`endif

    // Strobes are gated by RESET so a stalled transfer or PLL reset is released in the reset cycle itself.
    assign mgmt_write     = (state_q == S_WRITE) && !RESET;
    assign pll_reset      = (state_q == S_PRST) && !RESET;
    assign mgmt_address   = (state_q == S_WRITE || state_q == S_READ) ? entry.addr : 6'd0;
    assign mgmt_writedata = (state_q == S_WRITE) ? wr_data : 32'd0;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FIN);
    assign error          = error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: random/directed requests, Avalon slave with stalls,
// PLL lock model; expected writes and completions are queued from the register-table rules.
module tb_pll_reconfig_seq;

    localparam int GAP = 8;
    localparam int RST = 8;
    localparam int TMO = 100;

    logic        CLK_50M = 1'b0;
    logic        RESET = 1'b1;
    logic        req = 1'b0;
    logic [31:0] cfg_m = '0;
    logic [31:0] cfg_k = '0;
    logic [31:0] cfg_c0 = '0;
    logic        busy, done, error;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic        pll_reset;
`ifdef PLLRECFG_READBACK_EN
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        cfg_mismatch;
    logic [31:0] slave_mem [64];
    bit          corrupt_m = 1'b0;
`endif

    pll_reconfig_seq #(.GAP_CYCLES(GAP), .RST_CYCLES(RST), .LOCK_TIMEOUT(TMO)) dut (
        .CLK_50M(CLK_50M), .RESET(RESET), .req(req),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c0(cfg_c0),
        .busy(busy), .done(done), .error(error),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .pll_reset(pll_reset)
`ifdef PLLRECFG_READBACK_EN
        , .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata), .cfg_mismatch(cfg_mismatch)
`endif
    );

    always #10 CLK_50M = ~CLK_50M;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } exp_wr_t;

    exp_wr_t     exp_wr[$];
    bit          exp_done[$];
    exp_wr_t     e;
    bit          ee;
    bit          exp_err = 1'b0;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_m, pend_k, pend_c0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_mode = 0;
    logic [5:0]  stall_addr = '0;
    int          stall_len = 0;
    int          stall_cnt = 0;
    int          lock_delay = 20;
    int          since_fall = 0;
    bit          lock_armed = 1'b0;
    int          run_chk_len = 0;
    logic [5:0]  run_chk_addr = '0;
    int          wr_run = 0, rst_run = 0, seq_idx = 0;
    int          last_acc_cyc = 0, fall_cyc = 0, acc_count = 0, done_count = 0;
    bit          prev_stall = 0, prev_rst = 0, prev_done = 0;
    bit          check_busy_next = 0, busy_next_exp = 0;
    logic [5:0]  stall_addr_prev = '0;
    logic [31:0] stall_data_prev = '0;

    function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void failNow(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, what);
    endfunction

    // Reference model: the eight register writes a request must produce, plus its completion.
    function automatic void pushSeq(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0);
        logic [5:0]  a [8];
        logic [31:0] d [8];
        a = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
        d = '{32'd0, m, k, 32'h0001_0000, c0, 32'd1, 32'd7, 32'd0};
        for (int i = 0; i < 8; i++) exp_wr.push_back('{a[i], d[i]});
        exp_done.push_back(exp_err);
    endfunction

    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0,
                                 input bit pending);
        @(posedge CLK_50M);
        #1;
        req = 1'b1;
        cfg_m = m;
        cfg_k = k;
        cfg_c0 = c0;
        if (pending) begin
            pend_m = m;
            pend_k = k;
            pend_c0 = c0;
            pend_valid = 1'b1;
        end else begin
            pushSeq(m, k, c0);
        end
        @(posedge CLK_50M);
        #1;
        req = 1'b0;
        cfg_m = $urandom;
        cfg_k = $urandom;
        cfg_c0 = $urandom;
    endtask

    task automatic waitDrain(input int limit);
        int i = 0;
        while (i < limit && (exp_wr.size() != 0 || exp_done.size() != 0 || pend_valid)) begin
            @(posedge CLK_50M);
            i++;
        end
        if (exp_wr.size() != 0 || exp_done.size() != 0 || pend_valid) begin
            failNow("drain_timeout", $sformatf("got %0d writes and %0d completions outstanding, expected 0",
                                               exp_wr.size(), exp_done.size()));
            exp_wr.delete();
            exp_done.delete();
            pend_valid = 1'b0;
        end
        repeat (4) @(posedge CLK_50M);
    endtask

    task automatic waitAccepted(input int target, input int limit);
        for (int i = 0; i < limit && acc_count < target; i++) @(posedge CLK_50M);
        if (acc_count < target)
            failNow("wait_write_timeout", $sformatf("got %0d accepted writes, expected %0d", acc_count, target));
    endtask

    always @(posedge CLK_50M) cyc <= cyc + 1;

    // Avalon slave and PLL lock model, updated just after each clock edge.
    always @(posedge CLK_50M) begin
        #1;
        if (mgmt_write) begin
            case (wr_mode)
                1: mgmt_waitrequest = ($urandom_range(0, 2) == 0);
                2: begin
                    if (mgmt_address == stall_addr && stall_cnt < stall_len) begin
                        mgmt_waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                    end
                end
                default: mgmt_waitrequest = 1'b0;
            endcase
        end else begin
            mgmt_waitrequest = 1'b0;
        end
        if (pll_reset) begin
            pll_locked = 1'b0;
            since_fall = 0;
            lock_armed = 1'b1;
        end else if (lock_armed) begin
            since_fall++;
            if (lock_delay >= 0 && since_fall >= lock_delay) begin
                pll_locked = 1'b1;
                lock_armed = 1'b0;
            end
        end
    end

`ifdef PLLRECFG_READBACK_EN
    initial for (int i = 0; i < 64; i++) slave_mem[i] = '0;
    always @(posedge CLK_50M)
        if (!RESET && mgmt_write && !mgmt_waitrequest) slave_mem[mgmt_address] <= mgmt_writedata;
    assign mgmt_readdata = slave_mem[mgmt_address] ^ ((corrupt_m && mgmt_address == 6'd4) ? 32'h1 : 32'h0);
`endif

    // Monitor: pops the scoreboard on every accepted write and every done pulse.
    always @(negedge CLK_50M) begin
        if (RESET) begin
            prev_stall = 0; prev_rst = 0; prev_done = 0;
            wr_run = 0; rst_run = 0; check_busy_next = 0;
        end else begin
            if (check_busy_next) begin
                checkOutput("busy_after_done", busy, busy_next_exp);
                check_busy_next = 0;
            end
            if (prev_stall && mgmt_write) begin
                checkOutput("stall_addr_stable", mgmt_address, stall_addr_prev);
                checkOutput("stall_data_stable", mgmt_writedata, stall_data_prev);
            end
`ifndef PLLRECFG_READBACK_EN
            if (mgmt_write && wr_run == 0 && seq_idx != 0)
                checkOutput("write_gap", cyc - last_acc_cyc, GAP + 1);
`endif
            wr_run = mgmt_write ? wr_run + 1 : 0;
            if (mgmt_write && !mgmt_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    failNow("unexpected_write", $sformatf("got write addr 0x%0h data 0x%0h, expected none",
                                                          mgmt_address, mgmt_writedata));
                end else begin
                    e = exp_wr.pop_front();
                    checkOutput("wr_addr", mgmt_address, e.a);
                    checkOutput("wr_data", mgmt_writedata, e.d);
                end
                if (run_chk_len != 0 && mgmt_address == run_chk_addr)
                    checkOutput("write_hold_len", wr_run, run_chk_len);
                last_acc_cyc = cyc;
                seq_idx = (seq_idx + 1) % 8;
                acc_count++;
            end
            prev_stall = mgmt_write && mgmt_waitrequest;
            stall_addr_prev = mgmt_address;
            stall_data_prev = mgmt_writedata;
            if (pll_reset) begin
                rst_run++;
            end else if (prev_rst) begin
                checkOutput("pll_reset_width", rst_run, RST);
                rst_run = 0;
                fall_cyc = cyc;
            end
            prev_rst = pll_reset;
            if (done) begin
                if (prev_done) begin
                    failNow("done_width", "got done high two cycles, expected one");
                end else if (exp_done.size() == 0) begin
                    failNow("unexpected_done", "got done pulse, expected none");
                end else begin
                    ee = exp_done.pop_front();
                    checkOutput("done_error", error, ee);
                    checkOutput("busy_at_done", busy, 1);
                    if (ee) checkOutput("timeout_latency", cyc - fall_cyc, TMO);
                    if (pend_valid) begin
                        pushSeq(pend_m, pend_k, pend_c0);
                        pend_valid = 1'b0;
                        busy_next_exp = 1'b1;
                    end else begin
                        busy_next_exp = 1'b0;
                    end
                    check_busy_next = 1;
                    done_count++;
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #1000000;
        failNow("watchdog", "got simulation still running, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_done, base_acc;
        repeat (4) @(posedge CLK_50M);
        #1;
        RESET = 1'b0;
        @(negedge CLK_50M);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_write", mgmt_write, 0);
        checkOutput("reset_addr", mgmt_address, 0);
        checkOutput("reset_wdata", mgmt_writedata, 0);
        checkOutput("reset_pll_reset", pll_reset, 0);

        $display("[TB] directed request, no stalls");
        applyStimulus(32'h0000_0404, 32'hB333_32DD, 32'h0002_0201, 1'b0);
        @(negedge CLK_50M);
        checkOutput("busy_after_req", busy, 1);
        waitDrain(2000);
        checkOutput("error_after_lock", error, 0);

        $display("[TB] five-cycle stall on the K write");
        wr_mode = 2; stall_addr = 6'd7; stall_len = 5; stall_cnt = 0;
        run_chk_addr = 6'd7; run_chk_len = 6;
        applyStimulus($urandom, 32'hB333_32DD, $urandom, 1'b0);
        waitDrain(2000);
        run_chk_len = 0; wr_mode = 0;

        $display("[TB] lock timeout");
        lock_delay = -1; exp_err = 1'b1;
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        waitDrain(2000);
        checkOutput("error_sticky", error, 1);
        lock_delay = 20; exp_err = 1'b0;
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        @(negedge CLK_50M);
        checkOutput("error_cleared", error, 0);
        waitDrain(2000);

        $display("[TB] two requests while busy, last one wins");
        base_done = done_count;
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        waitAccepted(acc_count + 1, 500);
        applyStimulus(32'h167, $urandom, $urandom, 1'b1);
        applyStimulus(32'h160, $urandom, $urandom, 1'b1);
        waitDrain(4000);
        checkOutput("done_pulses", done_count - base_done, 2);

        $display("[TB] randomized requests with random waitrequest");
        for (int n = 0; n < 5; n++) begin
            wr_mode = 1;
            lock_delay = $urandom_range(1, 30);
            applyStimulus($urandom, $urandom, $urandom, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                waitAccepted(acc_count + 2, 1000);
                applyStimulus($urandom, $urandom, $urandom, 1'b1);
            end
            waitDrain(6000);
        end
        wr_mode = 0; lock_delay = 20;

`ifdef PLLRECFG_READBACK_EN
        $display("[TB] readback with corrupted M");
        checkOutput("no_mismatch", cfg_mismatch, 0);
        corrupt_m = 1'b1;
        base_done = done_count;
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        waitDrain(3000);
        checkOutput("mismatch_flag", cfg_mismatch, 1);
        checkOutput("mismatch_done", done_count - base_done, 1);
        corrupt_m = 1'b0;
`endif

        $display("[TB] reset during stalled C0 write");
        wr_mode = 2; stall_addr = 6'd5; stall_len = 1000000; stall_cnt = 0;
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        applyStimulus($urandom, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK_50M);
            if (mgmt_write && mgmt_address == 6'd5) break;
        end
        checkOutput("reached_c0_write", {mgmt_write, mgmt_address}, {1'b1, 6'd5});
        repeat (2) @(negedge CLK_50M);
        @(posedge CLK_50M);
        #1;
        RESET = 1'b1;
        exp_wr.delete(); exp_done.delete(); pend_valid = 1'b0; seq_idx = 0;
        @(negedge CLK_50M);
        checkOutput("write_drop_in_reset", mgmt_write, 0);
        @(posedge CLK_50M);
        #1;
        RESET = 1'b0;
        wr_mode = 0; stall_cnt = 0;
        @(negedge CLK_50M);
        checkOutput("post_reset_write", mgmt_write, 0);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_pll_reset", pll_reset, 0);
        base_done = done_count; base_acc = acc_count;
        repeat (200) @(posedge CLK_50M);
        checkOutput("no_done_after_reset", done_count - base_done, 0);
        checkOutput("no_write_after_reset", acc_count - base_acc, 0);

        $display("[TB] recovery request after reset");
        applyStimulus($urandom, $urandom, $urandom, 1'b0);
        waitDrain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer between the test-control logic and the Altera PLL reconfiguration controller's Avalon-MM management port.
- Accepts one frequency request as M/K/C0 counter words and writes the fixed eight-register reconfiguration sequence, honouring waitrequest.
- Then pulses the PLL reset, waits for lock, and reports completion or failure.
- Replaces the ad-hoc state[2:0]-spaced write timing with a proper handshake.

Parameters:
- GAP_CYCLES, 8: idle cycles between consecutive accepted writes (min 1).
- RST_CYCLES, 8: width of the pll_reset pulse in clocks.
- LOCK_TIMEOUT, 5000000: clocks to wait for lock after the reset pulse (100 ms at 50 MHz).

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  single-cycle request to reconfigure.
- cfg_m  in  32  M counter word.
- cfg_k  in  32  K (fractional) word.
- cfg_c0  in  32  C0 counter word.
- busy  out  1  high from request accept until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky lock-timeout flag.
- mgmt_address  out  6  Avalon-MM address.
- mgmt_writedata  out  32  Avalon-MM write data.
- mgmt_write  out  1  Avalon-MM write strobe.
- mgmt_waitrequest  in  1  Avalon-MM stall.
- pll_locked  in  1  PLL lock, already synchronous to CLK_50M.
- pll_reset  out  1  PLL reset request.

Behaviour:
- Reset values: busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, pll_reset=0. State IDLE, pending flag cleared.
- States:
  - IDLE
  - WRITE: mgmt_write asserted for entry idx.
  - GAP: count GAP_CYCLES.
  - PRST: pll_reset high for RST_CYCLES.
  - LOCKWAIT
  - FIN: done pulse.
- Write table, in order idx 0..7 (address:data):
  - 0: 0 (mode)
  - 4: M
  - 7: K
  - 3: 0x10000 (N)
  - 5: C0
  - 9: 1 (charge pump)
  - 8: 7 (bandwidth)
  - 2: 0 (start)
- IDLE, req=1:
  - Latch cfg_m/k/c0 into shadow registers.
  - busy=1 the next cycle; clear error; enter WRITE idx=0.
- WRITE:
  - mgmt_write=1 with address/data stable while mgmt_waitrequest=1.
  - The write is accepted on the first cycle mgmt_waitrequest=0; mgmt_write drops the following cycle.
  - Then enter GAP. After GAP_CYCLES, idx+1 → WRITE; after idx 7 → PRST.
- PRST: pll_reset=1 for exactly RST_CYCLES clocks, then → LOCKWAIT, with the timeout counter cleared.
- LOCKWAIT:
  - pll_locked=1 → FIN.
  - Counter reaching LOCK_TIMEOUT-1 → error=1, then FIN.
  - A lock level from before PRST is ignored, because the counter starts only after pll_reset falls.
- FIN:
  - done=1 for one cycle.
  - If pending: reload the shadow registers from the pending copy and go to WRITE idx=0, keeping busy=1.
  - Otherwise busy=0 → IDLE.
- req while busy:
  - Stores inputs into a one-deep pending slot.
  - Later requests overwrite it (last wins).
  - Never aborts a write in progress.
- Simultaneous req and FIN: the request becomes pending and is served immediately.
- RESET mid-operation:
  - Returns to IDLE next edge and deasserts mgmt_write immediately, even if waitrequest is high.
  - Deasserts pll_reset immediately and drops any pending request.
- Counters are sized by $clog2 of their parameter. No wrap is possible since all counters saturate or are reset on state entry.

Optional Feature:
- PLLRECFG_READBACK_EN.
- When defined:
  - Adds ports mgmt_read (out 1) and mgmt_readdata (in 32).
  - After each write, issues a read of the same address, using the same waitrequest rule.
  - Compares the result against the written data, except for idx 0 and 7, which are not compared.
  - On a mismatch, sets a sticky output cfg_mismatch (out 1) and continues the sequence.
- When undefined: the ports are absent, mgmt_read is not generated, and timing is as above.

Decomposition:
- Package pll_reconfig_pkg holds:
  - The register address localparams (MODE=0, START=2, N=3, M=4, C0=5, K=7, BW=8, CP=9).
  - The fixed N/CP/BW data constants.
  - The state enum typedef.
  - The write-table entry struct {addr, data-select}.
- Single module; no sub-module, since the write table is a combinational case on idx.

Test Plan:
- Directed single request, waitrequest always 0, lock 20 cycles after pll_reset falls:
  - req with M=0x00404, K=0xB33332DD, C0=0x20201.
  - Eight writes appear in the order 0,4,7,3,5,9,8,2 with correct data, each 8 idle cycles apart.
  - pll_reset is high exactly 8 cycles.
  - done pulses once; busy falls with done; error=0.
- Waitrequest stall of 5 cycles on the K write: mgmt_write is held 6 cycles with address 7 and data 0xB33332DD stable, and the sequence resumes.
- Lock never asserts, LOCK_TIMEOUT set to 100 in the bench: error=1 and done pulses 100 cycles after pll_reset falls; error clears on the next req.
- Two reqs during busy, M=0x167 then M=0x160: after the first done, a second sequence runs with M=0x160 only, giving a total of 2 done pulses.
- RESET asserted during the C0 write with waitrequest=1: next cycle mgmt_write=0, busy=0, pll_reset=0, and no done pulse.
- PLLRECFG_READBACK_EN defined, bench returns a wrong M on readback: cfg_mismatch=1 and the sequence still completes with done.
